master_route_decoder: RTL and testbench

- Sits on the master-to-slave path of the system bus, opposite the slave-to-master response mux.
- After the arbiter grants the bus to master 1 or master 2, it deserialises a 2-bit slave address from the granted master's serial line.
- It then registers `slave_grant`, which the response mux also consumes, and forwards the master's serial signals to the addressed slave until the grant is withdrawn.
- Bad addresses and stalled address phases are flagged.

---
 rtl/master_route_decoder.sv | 192 +++++++++++++++++++
 tb/tb_master_route_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/master_route_decoder.sv
// master_route_decoder: takes a 2-bit slave address, sent MSB first, from the
// master that holds the bus grant. It then forwards that master's serial
// signals to the addressed slave until the grant is withdrawn.
module master_route_decoder #(
  parameter int ADDR_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bus_grant,
  input  logic       m1_valid,
  input  logic       m1_tx_data,
  input  logic       m1_tx_done,
  input  logic       m2_valid,
  input  logic       m2_tx_data,
  input  logic       m2_tx_done,
  output logic [2:0] slave_grant,
  output logic [2:0] s_valid,
  output logic [2:0] s_tx_data,
  output logic [2:0] s_tx_done,
  output logic       busy,
  output logic       addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    ROUTE = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(ADDR_TIMEOUT - 1);

  localparam logic [2:0] SG_NONE = 3'b000;
  localparam logic [2:0] SG_S1   = 3'b011;
  localparam logic [2:0] SG_S2   = 3'b101;
  localparam logic [2:0] SG_S3   = 3'b111;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] addr_sh_q, addr_sh_d;
  logic       bit_cnt_q, bit_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0] slave_grant_q, slave_grant_d;
  logic       addr_err_q, addr_err_d;

  logic act_valid, act_tx_data, act_tx_done;
  logic grant_lost;

  // Select the serial signals of the master that currently owns the route
  always_comb begin
    act_valid   = 1'b0;
    act_tx_data = 1'b0;
    act_tx_done = 1'b0;
    case (owner_q)
      2'b01: begin
        act_valid   = m1_valid;
        act_tx_data = m1_tx_data;
        act_tx_done = m1_tx_done;
      end
      2'b10: begin
        act_valid   = m2_valid;
        act_tx_data = m2_tx_data;
        act_tx_done = m2_tx_done;
      end
      default: ;
    endcase
  end

  assign grant_lost = (bus_grant != owner_q);

  // Next-state logic: address capture, decode, timeout and grant tracking
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_sh_d     = addr_sh_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    slave_grant_d = slave_grant_q;
    addr_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        slave_grant_d = SG_NONE;
        if (bus_grant == 2'b01 || bus_grant == 2'b10) begin
          owner_d   = bus_grant;
          addr_sh_d = 2'b00;
          bit_cnt_d = 1'b0;
          tmo_cnt_d = 8'd0;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (grant_lost) begin
          owner_d       = 2'b00;
          slave_grant_d = SG_NONE;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (act_valid) begin
            addr_sh_d = {addr_sh_q[0], act_tx_data};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          // A completed address takes precedence over a simultaneous timeout.
          // Only the previously shifted bit matters here; bit 1 is stale.
          if (act_valid && bit_cnt_q) begin
            casez ({addr_sh_q, act_tx_data})
              3'b?01: begin slave_grant_d = SG_S1; state_d = ROUTE; end
              3'b?10: begin slave_grant_d = SG_S2; state_d = ROUTE; end
              3'b?11: begin slave_grant_d = SG_S3; state_d = ROUTE; end
              default: begin
                slave_grant_d = SG_NONE;
                addr_err_d    = 1'b1;
                state_d       = ERR;
              end
            endcase
          end else if (tmo_cnt_q == TMO_LAST) begin
            slave_grant_d = SG_NONE;
            addr_err_d    = 1'b1;
            state_d       = ERR;
          end
        end
      end
      ROUTE: begin
        if (grant_lost) begin
          owner_d       = 2'b00;
          slave_grant_d = SG_NONE;
          state_d       = IDLE;
        end
      end
      ERR: begin
        slave_grant_d = SG_NONE;
        if (grant_lost) begin
          owner_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 2'b00;
      addr_sh_q     <= 2'b00;
      bit_cnt_q     <= 1'b0;
      tmo_cnt_q     <= 8'd0;
      slave_grant_q <= SG_NONE;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      addr_sh_q     <= addr_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      slave_grant_q <= slave_grant_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Forward the active master's signals to the selected slave only in ROUTE
  always_comb begin
    s_valid   = 3'b000;
    s_tx_data = 3'b000;
    s_tx_done = 3'b000;
    if (state_q == ROUTE) begin
      case (slave_grant_q)
        SG_S1: begin
          s_valid[0]   = act_valid;
          s_tx_data[0] = act_tx_data;
          s_tx_done[0] = act_tx_done;
        end
        SG_S2: begin
          s_valid[1]   = act_valid;
          s_tx_data[1] = act_tx_data;
          s_tx_done[1] = act_tx_done;
        end
        SG_S3: begin
          s_valid[2]   = act_valid;
          s_tx_data[2] = act_tx_data;
          s_tx_done[2] = act_tx_done;
        end
        default: ;
      endcase
    end
  end

  assign slave_grant = slave_grant_q;
  assign busy        = (state_q != IDLE);
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_master_route_decoder.sv
// Directed scoreboard bench for master_route_decoder.
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled on the falling edge of the same cycle.
module tb_master_route_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] bus_grant;
  logic       m1_valid, m1_tx_data, m1_tx_done;
  logic       m2_valid, m2_tx_data, m2_tx_done;
  logic [2:0] slave_grant, s_valid, s_tx_data, s_tx_done;
  logic       busy, addr_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];

  master_route_decoder #(.ADDR_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_grant  (bus_grant),
    .m1_valid   (m1_valid),
    .m1_tx_data (m1_tx_data),
    .m1_tx_done (m1_tx_done),
    .m2_valid   (m2_valid),
    .m2_tx_data (m2_tx_data),
    .m2_tx_done (m2_tx_done),
    .slave_grant(slave_grant),
    .s_valid    (s_valid),
    .s_tx_data  (s_tx_data),
    .s_tx_done  (s_tx_done),
    .busy       (busy),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop the expectation for this cycle and compare it with the DUT outputs
  always @(negedge clk) begin
    exp_t        t;
    logic [13:0] act;
    if (sb.size() != 0) begin
      t   = sb.pop_front();
      act = {slave_grant, s_valid, s_tx_data, s_tx_done, busy, addr_err};
      checks++;
      if (act !== t.exp) begin
        errors++;
        $display("FAIL %s: got sg=%b sv=%b sd=%b sdn=%b busy=%b err=%b, expected sg=%b sv=%b sd=%b sdn=%b busy=%b err=%b",
                 t.nm, act[13:11], act[10:8], act[7:5], act[4:2], act[1], act[0],
                 t.exp[13:11], t.exp[10:8], t.exp[7:5], t.exp[4:2], t.exp[1], t.exp[0]);
      end
    end
  end

  // One cycle: drive the inputs, queue the expected outputs for this cycle, advance
  // m1/m2 = {valid, data, done}
  task automatic cyc(input logic r, input logic [1:0] g,
                     input logic [2:0] m1, input logic [2:0] m2,
                     input logic [2:0] sg, input logic [2:0] sv,
                     input logic [2:0] sd, input logic [2:0] sdn,
                     input logic b, input logic e, input string nm);
    exp_t t;
    rst        = r;
    bus_grant  = g;
    m1_valid   = m1[2];
    m1_tx_data = m1[1];
    m1_tx_done = m1[0];
    m2_valid   = m2[2];
    m2_tx_data = m2[1];
    m2_tx_done = m2[0];
    t.exp = {sg, sv, sd, sdn, b, e};
    t.nm  = nm;
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  localparam logic [2:0] Z = 3'b000;

  initial begin
    rst = 1'b1; bus_grant = 2'b00;
    m1_valid = 0; m1_tx_data = 0; m1_tx_done = 0;
    m2_valid = 0; m2_tx_data = 0; m2_tx_done = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 2'b00, Z, Z, Z, Z, Z, Z, 0, 0, "reset_hold");
    cyc(0, 2'b00, Z, Z, Z, Z, Z, Z, 0, 0, "reset_out");

    // m1 addresses slave 2 (bits 1,0), then sends data 1,1,0
    cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 0, 0, "s1_grant");
    cyc(0, 2'b01, 3'b110, Z, Z, Z, Z, Z, 1, 0, "s1_bit1");
    cyc(0, 2'b01, 3'b100, Z, Z, Z, Z, Z, 1, 0, "s1_bit0");
    cyc(0, 2'b01, 3'b110, Z, 3'b101, 3'b010, 3'b010, Z, 1, 0, "s1_data1a");
    cyc(0, 2'b01, 3'b110, Z, 3'b101, 3'b010, 3'b010, Z, 1, 0, "s1_data1b");
    cyc(0, 2'b01, 3'b100, Z, 3'b101, 3'b010, 3'b000, Z, 1, 0, "s1_data0");
    cyc(0, 2'b01, 3'b001, Z, 3'b101, Z, Z, 3'b010, 1, 0, "s1_done");
    cyc(0, 2'b00, 3'b110, Z, 3'b101, 3'b010, 3'b010, Z, 1, 0, "s1_drop_cycle");
    cyc(0, 2'b00, 3'b110, Z, Z, Z, Z, Z, 0, 0, "s1_after_drop");

    // m2 addresses slave 3 (bits 1,1); m1 noise must be ignored
    cyc(0, 2'b10, Z, Z, Z, Z, Z, Z, 0, 0, "s2_grant");
    cyc(0, 2'b10, 3'b100, 3'b110, Z, Z, Z, Z, 1, 0, "s2_bit1a");
    cyc(0, 2'b10, Z, 3'b110, Z, Z, Z, Z, 1, 0, "s2_bit1b");
    cyc(0, 2'b10, Z, 3'b001, 3'b111, Z, Z, 3'b100, 1, 0, "s2_done");
    cyc(0, 2'b10, 3'b111, 3'b110, 3'b111, 3'b100, 3'b100, Z, 1, 0, "s2_data");
    cyc(0, 2'b00, Z, Z, 3'b111, Z, Z, Z, 1, 0, "s2_drop_cycle");
    cyc(0, 2'b00, Z, Z, Z, Z, Z, Z, 0, 0, "s2_after_drop");

    // Address 00 -> error, stay in ERR until grant goes away
    cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 0, 0, "e_grant");
    cyc(0, 2'b01, 3'b100, Z, Z, Z, Z, Z, 1, 0, "e_bit0a");
    cyc(0, 2'b01, 3'b100, Z, Z, Z, Z, Z, 1, 0, "e_bit0b");
    cyc(0, 2'b01, 3'b110, Z, Z, Z, Z, Z, 1, 1, "e_pulse");
    cyc(0, 2'b01, 3'b110, Z, Z, Z, Z, Z, 1, 0, "e_hold");
    cyc(0, 2'b00, Z, Z, Z, Z, Z, Z, 1, 0, "e_drop_cycle");
    cyc(0, 2'b00, Z, Z, Z, Z, Z, Z, 0, 0, "e_idle");

    // Timeout: 16 ADDR cycles without valid bits
    cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 0, 0, "t_grant");
    for (int k = 0; k < 16; k++)
      cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 1, 0, "t_wait");
    cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 1, 1, "t_pulse");
    cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 1, 0, "t_err_hold");
    cyc(0, 2'b00, Z, Z, Z, Z, Z, Z, 1, 0, "t_drop_cycle");
    cyc(0, 2'b00, Z, Z, Z, Z, Z, Z, 0, 0, "t_idle");

    // Second address bit on the timeout cycle -> decode wins (address 01)
    cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 0, 0, "tw_grant");
    for (int k = 0; k < 14; k++)
      cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 1, 0, "tw_wait");
    cyc(0, 2'b01, 3'b100, Z, Z, Z, Z, Z, 1, 0, "tw_bit0");
    cyc(0, 2'b01, 3'b110, Z, Z, Z, Z, Z, 1, 0, "tw_bit1_on_tmo");

    // Routed to slave 1; grant switches straight to m2
    cyc(0, 2'b01, 3'b110, Z, 3'b011, 3'b001, 3'b001, Z, 1, 0, "h_route_s1");
    cyc(0, 2'b10, 3'b110, Z, 3'b011, 3'b001, 3'b001, Z, 1, 0, "h_switch_cycle");
    cyc(0, 2'b10, 3'b110, Z, Z, Z, Z, Z, 0, 0, "h_idle_gap");
    cyc(0, 2'b10, 3'b110, 3'b110, Z, Z, Z, Z, 1, 0, "h_m2_bit1a");
    cyc(0, 2'b10, Z, 3'b110, Z, Z, Z, Z, 1, 0, "h_m2_bit1b");
    cyc(0, 2'b10, 3'b111, Z, 3'b111, Z, Z, Z, 1, 0, "h_m1_ignored");
    cyc(0, 2'b10, Z, 3'b100, 3'b111, 3'b100, Z, Z, 1, 0, "h_m2_data0");

    // Reset mid-ROUTE
    cyc(1, 2'b10, Z, 3'b110, 3'b111, 3'b100, 3'b100, Z, 1, 0, "r_route_rst");
    cyc(0, 2'b00, Z, 3'b110, Z, Z, Z, Z, 0, 0, "r_route_after");

    // Reset mid-ADDR after one address bit
    cyc(0, 2'b01, Z, Z, Z, Z, Z, Z, 0, 0, "r_addr_grant");
    cyc(0, 2'b01, 3'b110, Z, Z, Z, Z, Z, 1, 0, "r_addr_bit1");
    cyc(1, 2'b01, 3'b110, Z, Z, Z, Z, Z, 1, 0, "r_addr_rst");
    cyc(0, 2'b00, 3'b110, Z, Z, Z, Z, Z, 0, 0, "r_addr_after");

    // Illegal grant 11 keeps the block idle
    cyc(0, 2'b11, Z, Z, Z, Z, Z, Z, 0, 0, "g11_a");
    cyc(0, 2'b11, 3'b110, 3'b110, Z, Z, Z, Z, 0, 0, "g11_b");
    cyc(0, 2'b00, Z, Z, Z, Z, Z, Z, 0, 0, "g11_c");

    // Let the monitor drain the queue, within a bound
    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
